arm_mem_stage: RTL and testbench

ARM_MEM_STAGE -- requirements
Module: arm_mem_stage

---
 rtl/arm_mem_stage.sv | 172 +++++++++++++++++
 tb/tb_arm_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mem_stage.sv
// ---------------------------------------------------------------------------
// arm_mem_stage
//   Memory stage of a 5-stage ARM-style pipeline. Issues load/store requests
//   on a simple req/ack data-memory port. It stalls the front of the pipeline
//   while a request is outstanding, forwards results combinationally (MEMID_*),
//   and registers the write-back results (MEMWB_*).
//
//   Optional feature: define ARM_MEM_TIMEOUT_EN to abort an access after
//   TIMEOUT_CYCLES WAIT cycles without ack. The abort sets the sticky
//   mem_timeout flag and retires a halt marker.
//
// Ports
//   clk, rst_b                 clock, synchronous active-low reset
//   EXMEM_*                    inputs from EX/MEM (held stable while mem_stall)
//   dmem_req/addr/wr_en/wdata  data-memory request side
//   dmem_ack/rdata             data-memory response side
//   mem_stall                  freeze fetch/decode/EX
//   MEMID_*                    combinational forwarding to decode
//   MEMWB_*                    registered write-back outputs
//   mem_timeout                sticky abort flag (tied 0 without the macro)
// ---------------------------------------------------------------------------
module arm_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] EXMEM_data_result,
    input  logic [31:0] EXMEM_rd_data,
    input  logic        EXMEM_rd_we,
    input  logic        EXMEM_rd_data_sel,
    input  logic [3:0]  EXMEM_des_reg_num,
    input  logic [3:0]  EXMEM_mem_write_en,
    input  logic        EXMEM_ld_byte_or_word,
    input  logic        EXMEM_internal_halted,
    output logic        dmem_req,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_wr_en,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        MEMID_rd_we,
    output logic [3:0]  MEMID_rd_num,
    output logic [31:0] MEMID_rd_data,
    output logic        MEMWB_rd_we,
    output logic [3:0]  MEMWB_rd_num,
    output logic [31:0] MEMWB_rd_data,
    output logic        MEMWB_internal_halted,
    output logic        mem_timeout
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        wb_we_q, wb_we_d;
    logic [3:0]  wb_num_q, wb_num_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_halt_q, wb_halt_d;

    logic        access;
    logic        abort;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    assign access = EXMEM_rd_data_sel | (|EXMEM_mem_write_en);

`ifdef ARM_MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tout_q, tout_d;

    // Abort fires in the WAIT cycle where the counter has already reached
    // the limit: the request is dropped and the stage retires a halt marker.
    assign abort = (state_q == S_WAIT) && !dmem_ack && (cnt_q == 8'(TIMEOUT_CYCLES));
    assign mem_timeout = tout_q;
`else
    assign abort = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    // State and result registers
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            wb_we_q   <= 1'b0;
            wb_num_q  <= '0;
            wb_data_q <= '0;
            wb_halt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_we_q   <= wb_we_d;
            wb_num_q  <= wb_num_d;
            wb_data_q <= wb_data_d;
            wb_halt_q <= wb_halt_d;
        end
    end

`ifdef ARM_MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        tout_d = tout_q | abort;
        if (state_q == S_IDLE && access && !dmem_ack)
            cnt_d = '0;
        else if (state_q == S_WAIT && !dmem_ack)
            cnt_d = cnt_q + 8'd1;
    end
`endif

    // Next-state and write-back register inputs
    always_comb begin
        state_d   = state_q;
        wb_num_d  = EXMEM_des_reg_num;
        wb_data_d = wb_data;
        wb_we_d   = EXMEM_rd_we;
        wb_halt_d = EXMEM_internal_halted;
        case (state_q)
            S_IDLE: if (access && !dmem_ack) state_d = S_WAIT;
            S_WAIT: if (dmem_ack || abort || !access) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            wb_we_d   = 1'b0;
            wb_halt_d = 1'b1;
        end else if (mem_stall) begin
            wb_we_d   = 1'b0;
            wb_halt_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        dmem_req   = rst_b & access & ~abort;
        mem_stall  = rst_b & access & ~dmem_ack & ~abort;
        dmem_addr  = EXMEM_data_result[31:2];
        dmem_wr_en = EXMEM_mem_write_en;
        dmem_wdata = EXMEM_ld_byte_or_word ? {4{EXMEM_rd_data[7:0]}} : EXMEM_rd_data;

        load_data = dmem_rdata;
        if (EXMEM_ld_byte_or_word) begin
            case (EXMEM_data_result[1:0])
                2'd0:    load_data = {24'd0, dmem_rdata[7:0]};
                2'd1:    load_data = {24'd0, dmem_rdata[15:8]};
                2'd2:    load_data = {24'd0, dmem_rdata[23:16]};
                default: load_data = {24'd0, dmem_rdata[31:24]};
            endcase
        end
        wb_data = EXMEM_rd_data_sel ? load_data : EXMEM_data_result;

        MEMID_rd_we   = EXMEM_rd_we & ~mem_stall & ~abort;
        MEMID_rd_num  = EXMEM_des_reg_num;
        MEMID_rd_data = wb_data;

        MEMWB_rd_we           = wb_we_q;
        MEMWB_rd_num          = wb_num_q;
        MEMWB_rd_data         = wb_data_q;
        MEMWB_internal_halted = wb_halt_q;
    end

endmodule

// File: tb/tb_arm_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_arm_mem_stage
//   Self-checking bench for arm_mem_stage: single-cycle vectors from a table,
//   then hand-written sequences for wait states, reset in WAIT, halt ordering
//   and timeout / indefinite WAIT.
// ---------------------------------------------------------------------------
module tb_arm_mem_stage;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] EXMEM_data_result, EXMEM_rd_data;
    logic        EXMEM_rd_we, EXMEM_rd_data_sel;
    logic [3:0]  EXMEM_des_reg_num, EXMEM_mem_write_en;
    logic        EXMEM_ld_byte_or_word, EXMEM_internal_halted;
    logic        dmem_req;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_wr_en;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        MEMID_rd_we;
    logic [3:0]  MEMID_rd_num;
    logic [31:0] MEMID_rd_data;
    logic        MEMWB_rd_we;
    logic [3:0]  MEMWB_rd_num;
    logic [31:0] MEMWB_rd_data;
    logic        MEMWB_internal_halted;
    logic        mem_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .EXMEM_data_result(EXMEM_data_result), .EXMEM_rd_data(EXMEM_rd_data),
        .EXMEM_rd_we(EXMEM_rd_we), .EXMEM_rd_data_sel(EXMEM_rd_data_sel),
        .EXMEM_des_reg_num(EXMEM_des_reg_num), .EXMEM_mem_write_en(EXMEM_mem_write_en),
        .EXMEM_ld_byte_or_word(EXMEM_ld_byte_or_word),
        .EXMEM_internal_halted(EXMEM_internal_halted),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wr_en(dmem_wr_en),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall),
        .MEMID_rd_we(MEMID_rd_we), .MEMID_rd_num(MEMID_rd_num), .MEMID_rd_data(MEMID_rd_data),
        .MEMWB_rd_we(MEMWB_rd_we), .MEMWB_rd_num(MEMWB_rd_num), .MEMWB_rd_data(MEMWB_rd_data),
        .MEMWB_internal_halted(MEMWB_internal_halted),
        .mem_timeout(mem_timeout)
    );

    typedef struct {
        logic [31:0] dr, rdd, rdata;
        logic        we, sel, byt, halt, ack;
        logic [3:0]  num, wen;
        logic        e_req, e_stall, e_idwe, e_wbwe, e_wbhalt;
        logic [3:0]  e_wen;
        logic [31:0] e_wdata, e_iddata, e_wbdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        EXMEM_data_result = '0; EXMEM_rd_data = '0; EXMEM_rd_we = 1'b0;
        EXMEM_rd_data_sel = 1'b0; EXMEM_des_reg_num = '0; EXMEM_mem_write_en = '0;
        EXMEM_ld_byte_or_word = 1'b0; EXMEM_internal_halted = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic load(input logic [31:0] addr, input logic byt, input logic [3:0] num,
                        input logic [31:0] rdata);
        idle_inputs();
        EXMEM_data_result = addr; EXMEM_rd_data_sel = 1'b1; EXMEM_rd_we = 1'b1;
        EXMEM_ld_byte_or_word = byt; EXMEM_des_reg_num = num; dmem_rdata = rdata;
    endtask

    initial begin
        //        dr            rdd           rdata         we sel byt hlt ack num   wen      req stl idwe wbwe wbh e_wen    e_wdata       e_iddata      e_wbdata
        vecs[0] = '{32'h12345678, 32'h0,        32'hDEADBEEF, 1, 0, 0, 0, 0, 4'd3, 4'b0000, 0, 0, 1, 1, 0, 4'b0000, 32'h00000000, 32'h12345678, 32'h12345678};
        vecs[1] = '{32'h00000101, 32'h123456E7, 32'h0,        0, 0, 1, 0, 1, 4'd5, 4'b0010, 1, 0, 0, 0, 0, 4'b0010, 32'hE7E7E7E7, 32'h00000101, 32'h00000101};
        vecs[2] = '{32'h00000203, 32'h0,        32'hCAFEF00D, 1, 1, 0, 0, 1, 4'd7, 4'b0000, 1, 0, 1, 1, 0, 4'b0000, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[3] = '{32'h00000100, 32'h0,        32'hAABBCCDD, 1, 1, 1, 0, 1, 4'd2, 4'b0000, 1, 0, 1, 1, 0, 4'b0000, 32'h00000000, 32'h000000DD, 32'h000000DD};
        vecs[4] = '{32'h00000103, 32'h0,        32'hAABBCCDD, 1, 1, 1, 0, 1, 4'd4, 4'b0000, 1, 0, 1, 1, 0, 4'b0000, 32'h00000000, 32'h000000AA, 32'h000000AA};
        vecs[5] = '{32'h00000101, 32'h0,        32'hAABBCCDD, 1, 1, 1, 0, 1, 4'd6, 4'b0000, 1, 0, 1, 1, 0, 4'b0000, 32'h00000000, 32'h000000CC, 32'h000000CC};
        vecs[6] = '{32'h00000040, 32'h11223344, 32'h0,        1, 0, 0, 0, 1, 4'd9, 4'b1111, 1, 0, 1, 1, 0, 4'b1111, 32'h11223344, 32'h00000040, 32'h00000040};
        vecs[7] = '{32'h00000000, 32'h0,        32'h0,        0, 0, 0, 1, 0, 4'd0, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000};

        // Reset: request and stall forced low even with a pending load
        rst_b = 1'b0;
        load(32'h0000_0010, 1'b0, 4'd1, 32'h1);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", mem_stall, 0);
        tick(); tick();
        chk("rst_wb_we", MEMWB_rd_we, 0);
        chk("rst_wb_num", MEMWB_rd_num, 0);
        chk("rst_wb_data", MEMWB_rd_data, 0);
        chk("rst_wb_halt", MEMWB_internal_halted, 0);
        chk("rst_timeout", mem_timeout, 0);
        idle_inputs();
        rst_b = 1'b1;
        tick();

        // Single-cycle table
        for (int i = 0; i < 8; i++) begin
            EXMEM_data_result = vecs[i].dr; EXMEM_rd_data = vecs[i].rdd;
            EXMEM_rd_we = vecs[i].we; EXMEM_rd_data_sel = vecs[i].sel;
            EXMEM_des_reg_num = vecs[i].num; EXMEM_mem_write_en = vecs[i].wen;
            EXMEM_ld_byte_or_word = vecs[i].byt; EXMEM_internal_halted = vecs[i].halt;
            dmem_ack = vecs[i].ack; dmem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
            chk($sformatf("v%0d_stall", i), mem_stall, vecs[i].e_stall);
            chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].dr >> 2);
            chk($sformatf("v%0d_wen", i), dmem_wr_en, vecs[i].e_wen);
            chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_id_we", i), MEMID_rd_we, vecs[i].e_idwe);
            chk($sformatf("v%0d_id_num", i), MEMID_rd_num, vecs[i].num);
            chk($sformatf("v%0d_id_data", i), MEMID_rd_data, vecs[i].e_iddata);
            tick();
            chk($sformatf("v%0d_wb_we", i), MEMWB_rd_we, vecs[i].e_wbwe);
            chk($sformatf("v%0d_wb_num", i), MEMWB_rd_num, vecs[i].num);
            chk($sformatf("v%0d_wb_data", i), MEMWB_rd_data, vecs[i].e_wbdata);
            chk($sformatf("v%0d_wb_halt", i), MEMWB_internal_halted, vecs[i].e_wbhalt);
        end

        // Byte load, two wait cycles, then a halt marker queued behind it
        load(32'h0000_0102, 1'b1, 4'd8, 32'hAABBCCDD);
        for (int w = 0; w < 2; w++) begin
            #1;
            chk("bl_stall", mem_stall, 1);
            chk("bl_req", dmem_req, 1);
            chk("bl_addr", dmem_addr, 30'h40);
            chk("bl_id_we", MEMID_rd_we, 0);
            tick();
            chk("bl_bubble_we", MEMWB_rd_we, 0);
            chk("bl_bubble_halt", MEMWB_internal_halted, 0);
        end
        dmem_ack = 1'b1;
        #1;
        chk("bl_ack_stall", mem_stall, 0);
        tick();
        chk("bl_wb_data", MEMWB_rd_data, 32'h000000BB);
        chk("bl_wb_we", MEMWB_rd_we, 1);
        chk("bl_wb_num", MEMWB_rd_num, 8);
        chk("bl_wb_halt", MEMWB_internal_halted, 0);
        idle_inputs();
        EXMEM_internal_halted = 1'b1;
        tick();
        chk("halt_after_load", MEMWB_internal_halted, 1);

        // Halt marker carried by a stalled access appears only on completion
        load(32'h0000_0200, 1'b0, 4'd1, 32'h0BADF00D);
        EXMEM_internal_halted = 1'b1;
        tick();
        chk("hs_stall_halt", MEMWB_internal_halted, 0);
        dmem_ack = 1'b1;
        tick();
        chk("hs_done_halt", MEMWB_internal_halted, 1);
        chk("hs_done_data", MEMWB_rd_data, 32'h0BADF00D);

        // Reset asserted on the second WAIT cycle abandons the access
        load(32'h0000_0300, 1'b0, 4'd2, 32'h77);
        tick(); tick();
        rst_b = 1'b0;
        #1;
        chk("rw_req", dmem_req, 0);
        chk("rw_stall", mem_stall, 0);
        tick();
        chk("rw_wb_we", MEMWB_rd_we, 0);
        chk("rw_wb_data", MEMWB_rd_data, 0);
        rst_b = 1'b1;
        idle_inputs();
        #1;
        chk("rw_idle_req", dmem_req, 0);
        tick();

        // Never-acked word load
        load(32'h0000_0400, 1'b0, 4'hA, 32'h55);
`ifdef ARM_MEM_TIMEOUT_EN
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("to_req", dmem_req, 1);
            chk("to_stall", mem_stall, 1);
            tick();
        end
        #1;
        chk("to_abort_req", dmem_req, 0);
        chk("to_abort_stall", mem_stall, 0);
        tick();
        chk("to_flag", mem_timeout, 1);
        chk("to_wb_halt", MEMWB_internal_halted, 1);
        chk("to_wb_we", MEMWB_rd_we, 0);
        idle_inputs();
        tick();
        chk("to_sticky", mem_timeout, 1);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk("to_rst_clear", mem_timeout, 0);
`else
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("nw_stall", mem_stall, 1);
            chk("nw_timeout", mem_timeout, 0);
            tick();
        end
        dmem_ack = 1'b1;
        tick();
        chk("nw_wb_data", MEMWB_rd_data, 32'h55);
        chk("nw_wb_we", MEMWB_rd_we, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
